// File: rtl/pc_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage.
//   fetch_state_e    : fetch FSM states (issue request / wait for response)
//   NOP_INSTR        : MIPS canonical NOP (sll $0,$0,0), used as the empty-slot word
//   DEFAULT_RESET_PC : default boot address
package pc_fetch_stage_pkg;

  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/pc_fetch_stage_add_four.sv
// add_Four: SIZE-bit +4 incrementer for the program counter.
//   pc_i       : current PC
//   pc_plus4_o : pc_i + 4, wrapping modulo 2^SIZE (no carry out)
module add_Four #(
  parameter int unsigned SIZE = 64
) (
  input  logic [SIZE-1:0] pc_i,
  output logic [SIZE-1:0] pc_plus4_o
);

  assign pc_plus4_o = pc_i + {{(SIZE-3){1'b0}}, 3'b100};

endmodule

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: instruction-fetch front end.
// Holds the PC, issues one instruction-memory request at a time, and captures
// the returned word into an IF/ID slot with a valid/ready handshake.
// Ports:
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   redirect_valid/redirect_pc : branch/jump redirect (target bits [1:0] dropped)
//   imem_req/imem_addr         : request to instruction memory (addr = PC)
//   imem_gnt                   : request accepted when imem_req && imem_gnt
//   imem_rvalid/imem_rdata     : one response per granted request
//   if_valid/if_pc/if_pc_plus4/if_instr : IF/ID slot contents
//   id_ready                   : decode consumes the slot when if_valid && id_ready
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int unsigned     SIZE     = 64,
  parameter logic [SIZE-1:0] RESET_PC = SIZE'(DEFAULT_RESET_PC),
  parameter int unsigned     INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [SIZE-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [SIZE-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [SIZE-1:0]   if_pc,
  output logic [SIZE-1:0]   if_pc_plus4,
  output logic [INST_W-1:0] if_instr,
  input  logic              id_ready
);

  fetch_state_e      state_q, state_d;
  logic [SIZE-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic              if_valid_q, if_valid_d;
  logic [SIZE-1:0]   if_pc_q, if_pc_d;
  logic [SIZE-1:0]   if_pc_plus4_q, if_pc_plus4_d;
  logic [INST_W-1:0] if_instr_q, if_instr_d;

  logic [SIZE-1:0]   pc_plus4;
  logic              slot_free;
  logic              req_fire;
  logic              load_slot;
  logic              unused_redirect_lsbs;

  // Target alignment forces the low two bits to zero.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  add_Four #(.SIZE(SIZE)) u_add_four (
    .pc_i       (pc_q),
    .pc_plus4_o (pc_plus4)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_REQ;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      if_instr_q    <= INST_W'(NOP_INSTR);
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_instr_q    <= if_instr_d;
    end
  end

  // Output / handshake decode. imem_req is held low while reset is asserted.
  always_comb begin
    slot_free = !if_valid_q || id_ready;
    imem_req  = rst_n && (state_q == FETCH_REQ) && !redirect_valid && slot_free;
    req_fire  = imem_req && imem_gnt;
    // A redirect in the same cycle as the response discards the response.
    load_slot = (state_q == FETCH_WAIT) && imem_rvalid && !kill_q && !redirect_valid;
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_instr_d    = if_instr_q;

    unique case (state_q)
      FETCH_REQ: begin
        if (req_fire) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH_REQ;
          kill_d  = 1'b0;
        end else if (redirect_valid) begin
          // Response still outstanding: remember to drop it on arrival.
          kill_d = 1'b1;
        end
      end
    endcase

    if (redirect_valid) pc_d = {redirect_pc[SIZE-1:2], 2'b00};
    else if (load_slot) pc_d = pc_plus4;

    // Load wins over a same-cycle consume.
    if (load_slot) begin
      if_valid_d    = 1'b1;
      if_pc_d       = pc_q;
      if_pc_plus4_d = pc_plus4;
      if_instr_d    = imem_rdata;
    end else if (redirect_valid || (if_valid_q && id_ready)) begin
      if_valid_d = 1'b0;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign if_instr    = if_instr_q;

endmodule
